// File: rtl/decoder_pkg.sv
// Shared widths, occupancy encodings and decode helper for the 2-to-4 stream decoder.
package decoder_pkg;

    localparam int unsigned CODE_W   = 2;
    localparam int unsigned ONEHOT_W = 4;
    localparam int unsigned OCC_W    = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // An encoder beat with V=0 carries no active line, so it decodes to all zeros.
    function automatic logic [ONEHOT_W-1:0] decode_code(
        input logic              v,
        input logic [CODE_W-1:0] code
    );
        logic [ONEHOT_W-1:0] w_word;
        w_word = '0;
        if (v) begin
            w_word = ONEHOT_W'(1) << code;
        end
        return w_word;
    endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry registered FIFO; the head entry drives the output directly so there is
// no combinational path from the push side to the pop side.
module skid_buf_2
    import decoder_pkg::*;
#(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
);

    occ_e              r_state;
    occ_e              w_state_nxt;
    logic              r_ready;
    logic              r_valid;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;

    logic              w_ready_nxt;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_tail_nxt;

    logic              w_accept;
    logic              w_pop;

    assign w_accept = i_valid & r_ready;
    assign w_pop    = r_valid & i_ready;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_valid <= w_valid_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Occupancy transitions
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (w_accept && !w_pop) begin
                    w_state_nxt = FULL;
                end else if (w_pop && !w_accept) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // Next values of the registered outputs and storage
    always_comb begin
        w_ready_nxt = (w_state_nxt != FULL);
        w_valid_nxt = (w_state_nxt != EMPTY);
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_head_nxt = i_data;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_head_nxt = i_data;
                end else if (w_accept) begin
                    w_tail_nxt = i_data;
                end else if (w_pop) begin
                    w_head_nxt = '0;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_head_nxt = r_tail;
                end
            end
            default: begin
                w_head_nxt = '0;
                w_tail_nxt = '0;
            end
        endcase
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_head;

endmodule

// File: rtl/decoder_2_4_stream.sv
// Streaming 2-to-4 decoder behind a 2-entry skid buffer, with saturating per-code
// event counters for beats carrying a valid code.
module decoder_2_4_stream
    import decoder_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CODE_W-1:0]     in_code,
    input  logic                  in_v,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ONEHOT_W-1:0]   out_onehot,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  clr_cnt,
    output logic [4*CNT_W-1:0]    cnt_flat
);

    localparam int unsigned NUM_CODES = ONEHOT_W;

    logic [ONEHOT_W-1:0] w_onehot;
    logic                w_in_ready;
    logic                w_accept;
    logic [CNT_W-1:0]    r_cnt [NUM_CODES];

    assign w_onehot = decode_code(in_v, in_code);
    assign w_accept = in_valid & w_in_ready;

    skid_buf_2 #(
        .DATA_W (ONEHOT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (in_valid),
        .i_data  (w_onehot),
        .o_ready (w_in_ready),
        .o_valid (out_valid),
        .o_data  (out_onehot),
        .i_ready (out_ready)
    );

    assign in_ready = w_in_ready;

    // Clear wins over a same-cycle accept; counts stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CODES; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (clr_cnt) begin
            for (int k = 0; k < NUM_CODES; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CODES; k++) begin
                if (w_accept && in_v && (in_code == CODE_W'(k)) && (r_cnt[k] != '1)) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < NUM_CODES; k++) begin
            cnt_flat[k*CNT_W +: CNT_W] = r_cnt[k];
        end
    end

endmodule

// File: tb/tb_decoder_2_4_stream.sv
// Directed bench for decoder_2_4_stream: one 8-bit-counter instance and one
// 2-bit-counter instance driven by the same stimulus.
module tb_decoder_2_4_stream;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_code;
    logic        in_v;
    logic        in_valid;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready_a;
    logic [3:0]  out_onehot_a;
    logic        out_valid_a;
    logic [31:0] cnt_a;

    logic        in_ready_b;
    logic [3:0]  out_onehot_b;
    logic        out_valid_b;
    logic [7:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    decoder_2_4_stream #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_v       (in_v),
        .in_valid   (in_valid),
        .in_ready   (in_ready_a),
        .out_onehot (out_onehot_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .clr_cnt    (clr_cnt),
        .cnt_flat   (cnt_a)
    );

    decoder_2_4_stream #(.CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_code    (in_code),
        .in_v       (in_v),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .out_onehot (out_onehot_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .clr_cnt    (clr_cnt),
        .cnt_flat   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_code   = 2'd0;
        in_v      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;

        // Reset values, asserted away from any edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_onehot",    32'(out_onehot_a), 32'd0);
        check("rst_in_ready",  32'(in_ready_a), 32'd0);
        check("rst_cnt",       cnt_a, 32'd0);
        in_valid = 1'b1; in_v = 1'b1; in_code = 2'd1;
        tick();
        tick();
        check("rst_drop_valid", 32'(out_valid_a), 32'd0);
        check("rst_hold_ready", 32'(in_ready_a), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre", 32'(in_ready_a), 32'd0);
        tick();
        check("rel_ready_post", 32'(in_ready_a), 32'd1);
        check("rel_cnt", cnt_a, 32'd0);

        // Sweep of all four codes, one per cycle
        out_ready = 1'b1;
        in_valid = 1'b1; in_v = 1'b1;
        in_code = 2'd0; tick(); check("sweep0", 32'(out_onehot_a), 32'h1);
        check("sweep0_valid", 32'(out_valid_a), 32'd1);
        in_code = 2'd1; tick(); check("sweep1", 32'(out_onehot_a), 32'h2);
        in_code = 2'd2; tick(); check("sweep2", 32'(out_onehot_a), 32'h4);
        in_code = 2'd3; tick(); check("sweep3", 32'(out_onehot_a), 32'h8);
        check("sweep_cnt", cnt_a, 32'h01010101);
        in_valid = 1'b0;
        tick();
        check("sweep_drain", 32'(out_valid_a), 32'd0);

        // V=0 beat is delivered as all zeros and not counted
        in_valid = 1'b1; in_v = 1'b0; in_code = 2'd3;
        tick();
        check("inv_valid",  32'(out_valid_a), 32'd1);
        check("inv_onehot", 32'(out_onehot_a), 32'h0);
        check("inv_cnt",    cnt_a, 32'h01010101);
        in_valid = 1'b0;
        tick();
        check("inv_drain", 32'(out_valid_a), 32'd0);

        // Backpressure: codes 1,2,3 offered while downstream stalls
        out_ready = 1'b0;
        in_valid = 1'b1; in_v = 1'b1; in_code = 2'd1;
        tick();
        check("bp_first",  32'(out_onehot_a), 32'h2);
        check("bp_ready1", 32'(in_ready_a), 32'd1);
        in_code = 2'd2;
        tick();
        check("bp_full_ready", 32'(in_ready_a), 32'd0);
        check("bp_hold1",      32'(out_onehot_a), 32'h2);
        in_code = 2'd3;
        tick();
        check("bp_hold2",      32'(out_onehot_a), 32'h2);
        check("bp_still_full", 32'(in_ready_a), 32'd0);
        check("bp_cnt_stall",  cnt_a, 32'h01020201);
        out_ready = 1'b1;
        tick();
        check("bp_out2",    32'(out_onehot_a), 32'h4);
        check("bp_ready_b", 32'(in_ready_a), 32'd1);
        tick();
        check("bp_out3",  32'(out_onehot_a), 32'h8);
        check("bp_valid", 32'(out_valid_a), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_drain", 32'(out_valid_a), 32'd0);
        check("bp_cnt",   cnt_a, 32'h02020201);

        // Reset while FULL and stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_v = 1'b1; in_code = 2'd0;
        tick();
        in_code = 2'd1;
        tick();
        check("mr_full", 32'(in_ready_a), 32'd0);
        in_code = 2'd2;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid_a), 32'd0);
        check("mr_cnt",   cnt_a, 32'd0);
        check("mr_cnt_b", 32'(cnt_b), 32'd0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tick();
        check("mr_ready",  32'(in_ready_a), 32'd1);
        check("mr_stale0", 32'(out_valid_a), 32'd0);
        out_ready = 1'b1;
        tick();
        check("mr_stale1", 32'(out_valid_a), 32'd0);

        // Saturation of the 2-bit counter, then clear racing an accept
        in_valid = 1'b1; in_v = 1'b1; in_code = 2'd3;
        for (int i = 0; i < 3; i++) tick();
        check("sat_at3", 32'(cnt_b), 32'hC0);
        for (int i = 0; i < 4; i++) tick();
        check("sat_stay3", 32'(cnt_b), 32'hC0);
        check("sat_wide7", cnt_a, 32'h07000000);
        clr_cnt = 1'b1;
        tick();
        check("clr_b", 32'(cnt_b), 32'h00);
        check("clr_a", cnt_a, 32'h0);
        check("clr_out", 32'(out_onehot_a), 32'h8);
        clr_cnt = 1'b0;
        in_valid = 1'b0;
        tick();
        check("clr_drain", 32'(out_valid_a), 32'd0);

        // Sixteen back-to-back beats with incrementing code
        in_valid = 1'b1; in_v = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] exp_oh;
            in_code = 2'(i);
            tick();
            exp_oh = 4'd1 << (i % 4);
            check("tp_ready",  32'(in_ready_a), 32'd1);
            check("tp_valid",  32'(out_valid_a), 32'd1);
            check("tp_onehot", 32'(out_onehot_a), 32'(exp_oh));
        end
        in_valid = 1'b0;
        check("tp_cnt_a", cnt_a, 32'h04040404);
        check("tp_cnt_b", 32'(cnt_b), 32'hFF);
        tick();
        check("tp_drain", 32'(out_valid_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
